// File: rtl/prv_trap_ctrl_if.sv
// prv_trap_ctrl_if: trap handshake between the hazard unit, CSR file and privilege trap controller
interface prv_trap_ctrl_if;
    logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
    logic        breakpoint, env, fault_insn_page, fault_load_page, fault_store_page;
    logic        mret, sret, wfi;
    logic [31:0] epc, badaddr;
    logic [1:0]  curr_privilege_level;
    logic        timer_int, soft_int, ext_int, global_ie;
    logic [31:0] mtvec, mepc, sepc;
    logic        pipe_clear;
    logic        intr, insert_pc, trap_commit, ret_commit, ret_is_s, wfi_stall;
    logic [31:0] priv_pc, cause, tval, trap_epc;

    modport slave (
        input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
               breakpoint, env, fault_insn_page, fault_load_page, fault_store_page,
               mret, sret, wfi, epc, badaddr, curr_privilege_level,
               timer_int, soft_int, ext_int, global_ie, mtvec, mepc, sepc, pipe_clear,
        output intr, insert_pc, priv_pc, trap_commit, ret_commit, ret_is_s,
               cause, tval, trap_epc, wfi_stall
    );

    modport master (
        output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
               breakpoint, env, fault_insn_page, fault_load_page, fault_store_page,
               mret, sret, wfi, epc, badaddr, curr_privilege_level,
               timer_int, soft_int, ext_int, global_ie, mtvec, mepc, sepc, pipe_clear,
        input  intr, insert_pc, priv_pc, trap_commit, ret_commit, ret_is_s,
               cause, tval, trap_epc, wfi_stall
    );
endinterface

// File: rtl/prv_trap_ctrl.sv
// prv_trap_ctrl: prioritises traps/xRET/WFI, latches cause/epc/tval and sequences the pipeline redirect
module prv_trap_ctrl #(
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [31:0] RESET_PC    = 32'h0000_0200
) (
    input logic           CLK,
    input logic           RST,
    prv_trap_ctrl_if.slave t
);
    typedef enum logic [1:0] {IDLE, WAIT_CLEAR, REDIRECT, WFI_WAIT} state_t;
    // Exception codes whose trap value is the faulting address
    localparam logic [15:0] TVAL_MASK = 16'b1011_0000_1111_0011;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d, tval_q, tval_d, epc_q, epc_d, priv_pc_q, priv_pc_d;
    logic        ret_q, ret_d, ret_is_s_q, ret_is_s_d;
    logic        any_int, irq, exc, take_trap;
    logic [4:0]  code;
    logic [31:0] base;

    always_comb begin
        any_int = t.ext_int | t.soft_int | t.timer_int;
        irq = t.global_ie & any_int;
        exc = |{t.fault_insn_page, t.fault_insn, t.illegal_insn, t.mal_insn, t.env, t.breakpoint,
                t.mal_s, t.mal_l, t.fault_store_page, t.fault_load_page, t.fault_s, t.fault_l};
        code = irq                ? (t.ext_int ? 5'd11 : t.soft_int ? 5'd3 : 5'd7) :
               t.fault_insn_page  ? 5'd12 :
               t.fault_insn       ? 5'd1  :
               t.illegal_insn     ? 5'd2  :
               t.mal_insn         ? 5'd0  :
               t.env              ? {3'b010, t.curr_privilege_level} :
               t.breakpoint       ? 5'd3  :
               t.mal_s            ? 5'd6  :
               t.mal_l            ? 5'd4  :
               t.fault_store_page ? 5'd15 :
               t.fault_load_page  ? 5'd13 :
               t.fault_s          ? 5'd7  : 5'd5;
        // A pending interrupt also pulls the core out of WFI straight into the trap path
        take_trap = (state_q == IDLE && (irq || exc)) || (state_q == WFI_WAIT && irq);
        base = {t.mtvec[31:2], 2'b00};
        state_d = state_q;
        cause_d = cause_q;
        tval_d = tval_q;
        epc_d = epc_q;
        priv_pc_d = priv_pc_q;
        ret_d = ret_q;
        ret_is_s_d = ret_is_s_q;
        if (take_trap) begin
            state_d = WAIT_CLEAR;
            cause_d = {irq, 26'd0, code};
            tval_d = (!irq && TVAL_MASK[code[3:0]]) ? t.badaddr : 32'd0;
            epc_d = t.epc;
            ret_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (t.mret || t.sret) begin
                        state_d = REDIRECT;
                        ret_d = 1'b1;
                        ret_is_s_d = ~t.mret;
                        priv_pc_d = t.mret ? t.mepc : t.sepc;
                    end else if (t.wfi) begin
                        state_d = WFI_WAIT;
                    end
                end
                WAIT_CLEAR: begin
                    if (t.pipe_clear) begin
                        state_d = REDIRECT;
                        priv_pc_d = (VECTORED_EN && cause_q[31] && t.mtvec[1:0] == 2'b01) ?
                                    base + {cause_q[29:0], 2'b00} : base;
                    end
                end
                REDIRECT: state_d = IDLE;
                WFI_WAIT: state_d = any_int ? IDLE : WFI_WAIT;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cause_q <= '0;
            tval_q <= '0;
            epc_q <= '0;
            priv_pc_q <= RESET_PC;
            ret_q <= 1'b0;
            ret_is_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tval_q <= tval_d;
            epc_q <= epc_d;
            priv_pc_q <= priv_pc_d;
            ret_q <= ret_d;
            ret_is_s_q <= ret_is_s_d;
        end
    end

    assign t.intr = state_q == WAIT_CLEAR;
    assign t.insert_pc = state_q == REDIRECT;
    assign t.trap_commit = state_q == REDIRECT && !ret_q;
    assign t.ret_commit = state_q == REDIRECT && ret_q;
    assign t.ret_is_s = ret_is_s_q;
    assign t.wfi_stall = state_q == WFI_WAIT;
    assign t.priv_pc = priv_pc_q;
    assign t.cause = cause_q;
    assign t.tval = tval_q;
    assign t.trap_epc = epc_q;
endmodule

// File: tb/tb_prv_trap_ctrl.sv
// tb_prv_trap_ctrl: directed scoreboard bench for the trap controller
module tb_prv_trap_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    prv_trap_ctrl_if t ();
    prv_trap_ctrl #(.VECTORED_EN(1'b1), .RESET_PC(32'h0000_0200)) dut (.CLK(CLK), .RST(RST), .t(t.slave));

    typedef struct {
        logic [31:0] pc, cause, tval;
        logic        ret, ret_s;
    } exp_t;
    typedef struct packed {
        logic [11:0] v;
        logic [1:0]  p;
        logic [4:0]  code;
        logic        tv;
    } ecase_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    ecase_t ec[12] = '{
        '{12'h001, 2'd3, 5'd5,  1'b1}, '{12'h003, 2'd3, 5'd7,  1'b1},
        '{12'h006, 2'd3, 5'd13, 1'b1}, '{12'h00C, 2'd3, 5'd15, 1'b1},
        '{12'h030, 2'd3, 5'd6,  1'b1}, '{12'h050, 2'd3, 5'd3,  1'b0},
        '{12'h0C0, 2'd0, 5'd8,  1'b0}, '{12'h080, 2'd1, 5'd9,  1'b0},
        '{12'h080, 2'd3, 5'd11, 1'b0}, '{12'h180, 2'd3, 5'd0,  1'b1},
        '{12'h300, 2'd3, 5'd2,  1'b0}, '{12'h600, 2'd3, 5'd1,  1'b1}
    };

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval,
                        input logic ret, input logic ret_s);
        exp_t e;
        e.pc = pc;
        e.cause = cause;
        e.tval = tval;
        e.ret = ret;
        e.ret_s = ret_s;
        sb.push_back(e);
    endtask

    task automatic drive_exc(input logic [11:0] v);
        {t.fault_insn_page, t.fault_insn, t.illegal_insn, t.mal_insn, t.env, t.breakpoint,
         t.mal_s, t.mal_l, t.fault_store_page, t.fault_load_page, t.fault_s, t.fault_l} = v;
    endtask

    task automatic check_sb();
        exp_t e;
        chk("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("insert_pc", {31'd0, t.insert_pc}, 32'd1);
            chk("intr_in_redirect", {31'd0, t.intr}, 32'd0);
            chk("priv_pc", t.priv_pc, e.pc);
            chk("trap_commit", {31'd0, t.trap_commit}, {31'd0, ~e.ret});
            chk("ret_commit", {31'd0, t.ret_commit}, {31'd0, e.ret});
            if (e.ret) chk("ret_is_s", {31'd0, t.ret_is_s}, {31'd0, e.ret_s});
            else begin
                chk("cause", t.cause, e.cause);
                chk("tval", t.tval, e.tval);
            end
        end
    endtask

    task automatic expect_redirect(input int max);
        int n = 0;
        while (t.insert_pc !== 1'b1 && n < max) begin
            step();
            n++;
        end
        if (t.insert_pc === 1'b1) check_sb();
        else chk("redirect_timeout", {31'd0, t.insert_pc}, 32'd1);
    endtask

    initial begin
        drive_exc('0);
        {t.mret, t.sret, t.wfi, t.timer_int, t.soft_int, t.ext_int, t.global_ie, t.pipe_clear} = '0;
        {t.epc, t.badaddr, t.mtvec, t.mepc, t.sepc} = '0;
        t.curr_privilege_level = 2'd3;
        step();
        step();
        chk("rst_intr", {31'd0, t.intr}, 32'd0);
        chk("rst_insert_pc", {31'd0, t.insert_pc}, 32'd0);
        chk("rst_priv_pc", t.priv_pc, 32'h0000_0200);
        chk("rst_cause", t.cause, 32'd0);
        chk("rst_tval", t.tval, 32'd0);
        chk("rst_wfi_stall", {31'd0, t.wfi_stall}, 32'd0);
        chk("rst_commits", {30'd0, t.trap_commit, t.ret_commit}, 32'd0);
        RST = 1'b0;
        step();

        t.mtvec = 32'h8000_0000;
        t.epc = 32'h100;
        t.badaddr = 32'h55;
        t.illegal_insn = 1'b1;
        push(32'h8000_0000, 32'd2, 32'd0, 1'b0, 1'b0);
        step();
        t.illegal_insn = 1'b0;
        chk("ill_intr_c1", {31'd0, t.intr}, 32'd1);
        chk("ill_insert_c1", {31'd0, t.insert_pc}, 32'd0);
        step();
        chk("ill_intr_c2", {31'd0, t.intr}, 32'd1);
        step();
        chk("ill_intr_c3", {31'd0, t.intr}, 32'd1);
        t.pipe_clear = 1'b1;
        step();
        check_sb();
        chk("ill_epc", t.trap_epc, 32'h100);
        t.pipe_clear = 1'b0;
        step();
        chk("ill_insert_pulse", {31'd0, t.insert_pc}, 32'd0);
        chk("ill_commit_pulse", {31'd0, t.trap_commit}, 32'd0);
        chk("ill_pc_hold", t.priv_pc, 32'h8000_0000);

        t.mtvec = 32'h8000_0001;
        t.global_ie = 1'b1;
        t.timer_int = 1'b1;
        push(32'h8000_001C, 32'h8000_0007, 32'd0, 1'b0, 1'b0);
        step();
        chk("tmr_intr", {31'd0, t.intr}, 32'd1);
        {t.timer_int, t.global_ie} = '0;
        t.pipe_clear = 1'b1;
        expect_redirect(4);
        t.pipe_clear = 1'b0;
        step();

        t.badaddr = 32'hDEAD_BEEC;
        t.fault_insn_page = 1'b1;
        t.mal_l = 1'b1;
        t.pipe_clear = 1'b1;
        push(32'h8000_0000, 32'd12, 32'hDEAD_BEEC, 1'b0, 1'b0);
        step();
        chk("prio_intr_with_clear", {31'd0, t.intr}, 32'd1);
        chk("prio_no_early_insert", {31'd0, t.insert_pc}, 32'd0);
        drive_exc('0);
        expect_redirect(4);
        t.pipe_clear = 1'b0;
        step();

        t.fault_insn_page = 1'b1;
        t.mal_l = 1'b1;
        t.ext_int = 1'b1;
        t.global_ie = 1'b1;
        push(32'h8000_002C, 32'h8000_000B, 32'd0, 1'b0, 1'b0);
        step();
        chk("ext_intr", {31'd0, t.intr}, 32'd1);
        drive_exc('0);
        {t.ext_int, t.global_ie} = '0;
        t.pipe_clear = 1'b1;
        expect_redirect(4);
        step();

        t.mtvec = 32'h0000_1000;
        t.badaddr = 32'hCAFE_0004;
        for (int i = 0; i < 12; i++) begin
            t.curr_privilege_level = ec[i].p;
            drive_exc(ec[i].v);
            push(32'h1000, {27'd0, ec[i].code}, ec[i].tv ? 32'hCAFE_0004 : 32'd0, 1'b0, 1'b0);
            step();
            chk("tbl_intr", {31'd0, t.intr}, 32'd1);
            drive_exc('0);
            expect_redirect(4);
            step();
        end
        t.pipe_clear = 1'b0;
        t.curr_privilege_level = 2'd3;

        t.mepc = 32'h1234;
        t.mret = 1'b1;
        push(32'h1234, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        check_sb();
        t.mret = 1'b0;
        step();
        chk("mret_pulse", {31'd0, t.ret_commit}, 32'd0);
        chk("mret_pc_hold", t.priv_pc, 32'h1234);
        t.sepc = 32'h40;
        t.sret = 1'b1;
        push(32'h40, 32'd0, 32'd0, 1'b1, 1'b1);
        step();
        check_sb();
        t.sret = 1'b0;
        step();
        t.mepc = 32'h88;
        t.sepc = 32'h44;
        {t.mret, t.sret} = 2'b11;
        push(32'h88, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        check_sb();
        {t.mret, t.sret} = 2'b00;
        step();
        t.illegal_insn = 1'b1;
        t.mret = 1'b1;
        push(32'h1000, 32'd2, 32'd0, 1'b0, 1'b0);
        step();
        chk("trap_over_mret_intr", {31'd0, t.intr}, 32'd1);
        chk("trap_over_mret_insert", {31'd0, t.insert_pc}, 32'd0);
        t.illegal_insn = 1'b0;
        t.mret = 1'b0;
        t.pipe_clear = 1'b1;
        expect_redirect(4);
        t.pipe_clear = 1'b0;
        step();

        t.wfi = 1'b1;
        step();
        t.wfi = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("wfi_stall_hi", {31'd0, t.wfi_stall}, 32'd1);
            if (i == 5) t.soft_int = 1'b1;
            step();
        end
        chk("wfi_stall_lo", {31'd0, t.wfi_stall}, 32'd0);
        chk("wfi_no_intr", {31'd0, t.intr}, 32'd0);
        step();
        chk("wfi_no_intr2", {31'd0, t.intr}, 32'd0);
        t.soft_int = 1'b0;
        step();

        t.global_ie = 1'b1;
        t.mtvec = 32'h8000_0000;
        t.wfi = 1'b1;
        push(32'h8000_0000, 32'h8000_0003, 32'd0, 1'b0, 1'b0);
        step();
        t.wfi = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("wfi_ie_stall_hi", {31'd0, t.wfi_stall}, 32'd1);
            if (i == 5) t.soft_int = 1'b1;
            step();
        end
        chk("wfi_ie_stall_lo", {31'd0, t.wfi_stall}, 32'd0);
        chk("wfi_ie_intr", {31'd0, t.intr}, 32'd1);
        {t.soft_int, t.global_ie} = '0;
        t.pipe_clear = 1'b1;
        expect_redirect(4);
        t.pipe_clear = 1'b0;
        step();

        t.illegal_insn = 1'b1;
        step();
        t.illegal_insn = 1'b0;
        chk("rst_mid_intr", {31'd0, t.intr}, 32'd1);
        step();
        RST = 1'b1;
        step();
        chk("rst_mid_intr_lo", {31'd0, t.intr}, 32'd0);
        chk("rst_mid_pc", t.priv_pc, 32'h0000_0200);
        chk("rst_mid_cause", t.cause, 32'd0);
        RST = 1'b0;
        t.pipe_clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mid_no_commit", {31'd0, t.trap_commit}, 32'd0);
            chk("rst_mid_no_insert", {31'd0, t.insert_pc}, 32'd0);
        end
        t.pipe_clear = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prv_trap_ctrl.md
Name: prv_trap_ctrl

Overview:
- Privilege-side endpoint of the hazard↔priv_block trap handshake.
- Consumes the exception strobes, xRET and WFI strobes raised by the hazard unit, plus the interrupt lines.
- Prioritises them, latches cause/epc/tval, and drives the redirect sequence: intr, then priv_pc/insert_pc.
- Emits a one-cycle commit pulse so the CSR file can update mcause/mepc/mtval/mstatus.

Parameters:
VECTORED_EN, 1, when 1 honour mtvec.MODE=1 (vectored interrupts); when 0 always direct.
RESET_PC, 32'h0000_0200, value of priv_pc out of reset.

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env, fault_insn_page, fault_load_page, fault_store_page  in  1 each  exception strobes from hazard unit
mret, sret, wfi  in  1 each  return / wait strobes
epc  in  32  PC of the faulting/returning instruction
badaddr  in  32  faulting address
curr_privilege_level  in  2  current privilege (U=0, S=1, M=3)
timer_int, soft_int, ext_int  in  1 each  interrupt pending lines, already masked by mie
global_ie  in  1  mstatus.MIE-derived global enable
mtvec, mepc, sepc  in  32 each  CSR values
pipe_clear  in  1  pipeline reports it is drained
intr  out  1  trap request to hazard unit
insert_pc  out  1  redirect strobe
priv_pc  out  32  redirect target
trap_commit  out  1  one-cycle CSR update pulse
ret_commit  out  1  one-cycle xRET CSR update pulse (ret_is_s selects sret)
ret_is_s  out  1  1 = sret
cause  out  32  {interrupt bit, 31-bit code}
tval  out  32  latched trap value
wfi_stall  out  1  hold pipeline while waiting for interrupt

Behaviour:
- Reset (RST=1 at CLK edge): state=IDLE; intr, insert_pc, trap_commit, ret_commit, ret_is_s, wfi_stall = 0; cause = tval = 0; priv_pc = RESET_PC. Reset mid-sequence aborts to IDLE with no commit.
- States: IDLE, WAIT_CLEAR, REDIRECT, WFI_WAIT.
- Interrupt pending: irq = global_ie & (ext_int | soft_int | timer_int).
- Interrupt priority and codes: ext=11 > soft=3 > timer=7.
- Exception priority and codes: fault_insn_page=12 > fault_insn=1 > illegal_insn=2 > mal_insn=0 > env (8+curr_privilege_level, i.e. 8/9/11) > breakpoint=3 > mal_s=6 > mal_l=4 > fault_store_page=15 > fault_load_page=13 > fault_s=7 > fault_l=5.
- Interrupts win over exceptions in the same cycle.
- A trap wins over mret/sret; mret wins over sret; a trap or xRET wins over wfi.
- IDLE, trap seen:
  - Latch cause: bit31=1 for interrupt, 0 for exception.
  - Latch tval = badaddr for codes 0,1,4,5,6,7,12,13,15; else 0.
  - Latch epc.
  - Next cycle: state=WAIT_CLEAR, intr=1.
- WAIT_CLEAR: hold intr=1 until pipe_clear=1. New strobes are ignored here (latched values are frozen). On pipe_clear, go to REDIRECT.
- REDIRECT, single cycle:
  - Outputs: insert_pc=1, trap_commit=1, intr=0.
  - Target for an interrupt with VECTORED_EN=1 and mtvec[1:0]=01: priv_pc = {mtvec[31:2],2'b00} + 4*code, 32-bit wrap.
  - Target otherwise: priv_pc = {mtvec[31:2],2'b00}.
  - Next state IDLE.
- IDLE, mret/sret seen: go straight to REDIRECT-return variant. priv_pc = mepc (or sepc); insert_pc=1, ret_commit=1, ret_is_s set accordingly; no intr, no pipe_clear wait. Next state IDLE.
- IDLE, wfi seen:
  - Go to WFI_WAIT with wfi_stall=1.
  - Leave when any of ext/soft/timer_int is set, regardless of global_ie; wfi_stall drops the next cycle.
  - If irq is set on exit, take the interrupt trap path.
- priv_pc holds its last value outside REDIRECT. insert_pc and commits are strictly one-cycle pulses.
- Exception strobe and pipe_clear in the same IDLE cycle: intr still asserts for at least one cycle before REDIRECT.
- Latency: trap strobe → intr is 1 cycle; pipe_clear → insert_pc is 1 cycle; xRET → insert_pc is 1 cycle.

Test Plan:
- Illegal: illegal_insn=1, epc=0x100, mtvec=0x8000_0000, pipe_clear at cycle+3 → intr high for cycles 1..3; insert_pc at cycle 4 with priv_pc=0x8000_0000, cause=2, tval=0, one trap_commit pulse.
- Vectored timer interrupt: global_ie=1, timer_int=1, mtvec=0x8000_0001 → cause=0x8000_0007, priv_pc=0x8000_001C.
- Priority: fault_insn_page and mal_l together, badaddr=0xDEAD_BEEC → cause=12, tval=0xDEAD_BEEC; with ext_int=1 and global_ie=1 in the same cycle → cause=0x8000_000B.
- Returns: mret with mepc=0x1234 → insert_pc next cycle, priv_pc=0x1234, ret_commit=1, ret_is_s=0. sret with sepc=0x40 → priv_pc=0x40, ret_is_s=1.
- WFI: wfi then soft_int at +5 with global_ie=0 → wfi_stall high 5 cycles then low, no intr. Repeat with global_ie=1 → trap with cause=0x8000_0003.
- Reset mid-trap: RST asserted during WAIT_CLEAR → next cycle intr=0, priv_pc=0x200, no trap_commit ever issued.
